ftoi_pipe: RTL and testbench



---
 rtl/ftoi_pkg.sv | 39 +++
 rtl/ftoi_round.sv | 30 +++
 rtl/ftoi_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ftoi_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftoi_pkg.sv
// ftoi_pkg: shared types, constants and helpers for the float-to-integer
// converter.
//   rm_e    - rounding mode encoding as it arrives on in_rm
//   flags_t - exception flags produced alongside each result
//   sat_val - saturation pattern for a given target width, signedness, sign
//             and NaN-ness (right-justified in 64 bits)
package ftoi_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic nv;
        logic nx;
    } flags_t;

    localparam int EXP_BIAS = 127;
    localparam int EXP_NAN  = 255;
    localparam int SIG_W    = 24;

    // NaN always saturates toward the positive end regardless of its sign bit.
    function automatic logic [63:0] sat_val(input int int_w, input logic is_unsigned,
                                            input logic sign, input logic nan);
        logic [63:0] ones;
        logic [63:0] r;
        ones = {64{1'b1}} >> (64 - int_w);
        if (is_unsigned)
            r = (nan | ~sign) ? ones : 64'd0;
        else
            r = (nan | ~sign) ? (ones >> 1) : ~(ones >> 1);
        return r;
    endfunction

endpackage

// File: rtl/ftoi_round.sv
// ftoi_round: combinational round-increment decision.
//   rm   - rounding mode (codes 5..7 behave as truncation)
//   sign - operand sign
//   lsb  - least significant bit of the truncated integer
//   g    - guard bit (first bit below the integer LSB)
//   st   - sticky bit (OR of all bits below the guard)
//   inc  - 1 when the truncated magnitude must be incremented
module ftoi_round
    import ftoi_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       st,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RNE:     inc = g & (st | lsb);
            RDN:     inc = sign & (g | st);
            RUP:     inc = ~sign & (g | st);
            RMM:     inc = g;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: three-stage binary32 to INT_W-bit integer converter.
//   S1 unpacks and aligns the operand, S2 applies the rounding increment,
//   S3 range-checks, negates or saturates and forms the flags.
// Ports:
//   clk, rstn                 - clock (rising edge), async active-low reset
//   in_valid/in_ready         - operand handshake
//   in_x, in_rm, in_unsigned  - operand, rounding mode, target signedness
//   out_valid/out_ready       - result handshake
//   out_y, out_nv, out_nx     - result and invalid/inexact flags
//
// Handshake: a beat moves on a rising edge where valid & ready are both 1.
// The whole pipe advances together when adv = ~out_valid | out_ready, and
// in_ready is adv itself, so it follows out_ready combinationally. While a
// result waits (out_valid & ~out_ready) nothing moves and out_* hold. Empty
// slots are not squeezed out.
module ftoi_pipe
    import ftoi_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [2:0]       in_rm,
    input  logic             in_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_y,
    output logic             out_nv,
    output logic             out_nx
);

    // Magnitude carries one extra bit so a rounding carry or 2^INT_W is visible.
    localparam int MW = INT_W + 1;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack / align ----------------
    logic              a_sign;
    logic [7:0]        a_exp;
    logic [22:0]       a_man;
    logic [SIG_W-1:0]  a_sig;
    logic signed [9:0] a_ue;
    logic [47:0]       a_frac;
    logic [4:0]        a_rsh;
    logic [6:0]        a_lsh;
    logic [MW-1:0]     a_int;
    logic              a_g, a_st, a_nan, a_inf, a_ovf;

    assign a_sign = in_x[31];
    assign a_exp  = in_x[30:23];
    assign a_man  = in_x[22:0];
    assign a_sig  = {1'b1, a_man};
    assign a_ue   = $signed({2'b00, a_exp}) - $signed(10'(EXP_BIAS));

    always_comb begin
        a_int  = '0;
        a_g    = 1'b0;
        a_st   = 1'b0;
        a_nan  = 1'b0;
        a_inf  = 1'b0;
        a_ovf  = 1'b0;
        a_frac = '0;
        a_rsh  = '0;
        a_lsh  = '0;
        if (a_exp == 8'd0) begin
            a_st = |a_man;
        end else if (a_exp == 8'(EXP_NAN)) begin
            a_nan = |a_man;
            a_inf = ~|a_man;
        end else if (a_ue < 10'sd0) begin
            // Only E = -1 puts the hidden bit in the guard position.
            a_g  = (a_ue == -10'sd1);
            a_st = (a_ue == -10'sd1) ? |a_man : 1'b1;
        end else if (a_ue < 10'sd23) begin
            a_rsh  = 5'(10'sd23 - a_ue);
            a_frac = {a_sig, 24'd0} >> a_rsh;
            a_int  = MW'(a_frac[47:24]);
            a_g    = a_frac[23];
            a_st   = |a_frac[22:0];
        end else if (a_ue >= $signed(10'(INT_W + 1))) begin
            a_ovf = 1'b1;
        end else begin
            a_lsh = 7'(a_ue - 10'sd23);
            a_int = MW'(a_sig) << a_lsh;
        end
    end

    logic          s1_valid, s1_sign, s1_uns, s1_g, s1_st, s1_nan, s1_inf, s1_ovf;
    logic [2:0]    s1_rm;
    logic [MW-1:0] s1_int;

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign <= a_sign;
            s1_uns  <= in_unsigned;
            s1_rm   <= in_rm;
            s1_int  <= a_int;
            s1_g    <= a_g;
            s1_st   <= a_st;
            s1_nan  <= a_nan;
            s1_inf  <= a_inf;
            s1_ovf  <= a_ovf;
        end
    end

    // ---------------- S2: round ----------------
    logic r_inc;

    ftoi_round u_round (
        .rm   (s1_rm),
        .sign (s1_sign),
        .lsb  (s1_int[0]),
        .g    (s1_g),
        .st   (s1_st),
        .inc  (r_inc)
    );

    logic          s2_valid, s2_sign, s2_uns, s2_inexact, s2_nan, s2_inf, s2_ovf;
    logic [MW-1:0] s2_mag;

    always_ff @(posedge clk) begin
        if (adv && s1_valid) begin
            s2_mag     <= s1_int + MW'(r_inc);
            s2_sign    <= s1_sign;
            s2_uns     <= s1_uns;
            s2_inexact <= s1_g | s1_st;
            s2_nan     <= s1_nan;
            s2_inf     <= s1_inf;
            s2_ovf     <= s1_ovf;
        end
    end

    // ---------------- S3: range check / negate / saturate ----------------
    logic             c_in_range, c_bad;
    logic [INT_W-1:0] c_mag, c_y;
    flags_t           c_flags;

    always_comb begin
        c_in_range = 1'b0;
        case ({s2_uns, s2_sign})
            2'b00:   c_in_range = ~s2_mag[INT_W] & ~s2_mag[INT_W-1];
            2'b01:   c_in_range = ~s2_mag[INT_W] &
                                  (~s2_mag[INT_W-1] | ~|s2_mag[INT_W-2:0]);
            2'b10:   c_in_range = ~s2_mag[INT_W];
            default: c_in_range = ~|s2_mag;
        endcase
        c_bad = s2_nan | s2_inf | s2_ovf | ~c_in_range;
        c_mag = s2_mag[INT_W-1:0];
        if (c_bad) begin
            c_y     = INT_W'(sat_val(INT_W, s2_uns, s2_sign, s2_nan));
            c_flags = '{nv: 1'b1, nx: 1'b0};
        end else begin
            c_y     = s2_sign ? -c_mag : c_mag;
            c_flags = '{nv: 1'b0, nx: s2_inexact};
        end
    end

    flags_t s3_flags;
    logic   s3_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            out_y    <= '0;
            s3_flags <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (s2_valid) begin
                out_y    <= c_y;
                s3_flags <= c_flags;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_nv    = s3_flags.nv;
    assign out_nx    = s3_flags.nx;

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: directed and randomised checks of ftoi_pipe at INT_W = 32
// and INT_W = 64. Both instances share operand and out_ready wiring; each
// has its own in_valid. Expected {nv, nx, y} entries are queued when an
// operand is offered and popped when the matching result leaves the DUT.
module tb_ftoi_pipe;
    import ftoi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        v32, v64, out_ready, in_uns;
    logic [31:0] in_x;
    logic [2:0]  in_rm;
    logic        rdy32, ov32, nv32, nx32;
    logic        rdy64, ov64, nv64, nx64;
    logic [31:0] y32;
    logic [63:0] y64;

    ftoi_pipe #(.INT_W(32)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(v32), .in_ready(rdy32), .in_x(in_x),
        .in_rm(in_rm), .in_unsigned(in_uns), .out_valid(ov32), .out_ready(out_ready),
        .out_y(y32), .out_nv(nv32), .out_nx(nx32)
    );

    ftoi_pipe #(.INT_W(64)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(v64), .in_ready(rdy64), .in_x(in_x),
        .in_rm(in_rm), .in_unsigned(in_uns), .out_valid(ov64), .out_ready(out_ready),
        .out_y(y64), .out_nv(nv64), .out_nx(nx64)
    );

    // ---------------- scoreboard state ----------------
    logic [65:0] exp32_q[$];
    logic [65:0] exp64_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Builds the binary32 encoding of a nonzero 24-bit integer (always exact).
    function automatic logic [31:0] int2f(input logic s, input logic [23:0] n);
        int          p;
        logic [23:0] t;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        t = n << (23 - p);
        return {s, 8'(127 + p), t[22:0]};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic w64, input logic [31:0] x, input logic [2:0] rm,
                        input logic uns, input logic [63:0] ey,
                        input logic env, input logic enx);
        logic got;
        got    = 1'b0;
        in_x   = x;
        in_rm  = rm;
        in_uns = uns;
        if (w64) begin
            v64 = 1'b1;
            exp64_q.push_back({env, enx, ey});
        end else begin
            v32 = 1'b1;
            exp32_q.push_back({env, enx, ey});
        end
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            got = w64 ? rdy64 : rdy32;
            @(posedge clk);
            #1;
        end
        v32 = 1'b0;
        v64 = 1'b0;
        check("accept", {63'd0, got}, 64'd1);
    endtask

    // ---------------- output monitor ----------------
    task automatic monitor();
        logic        hv32, hv64;
        logic [33:0] h32;
        logic [65:0] h64;
        logic [65:0] e;
        hv32 = 1'b0;
        hv64 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hv32 = 1'b0;
                hv64 = 1'b0;
            end else begin
                if (hv32) check("hold32", {30'd0, nv32, nx32, y32}, {30'd0, h32});
                if (hv64) check("hold64", y64 ^ {62'd0, nv64, nx64},
                                h64[63:0] ^ {62'd0, h64[65:64]});
                if (ov32 && out_ready) begin
                    if (exp32_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $error("FAIL spurious32: observed %h expected no result", y32);
                    end else begin
                        e = exp32_q.pop_front();
                        check("y32", {32'd0, y32}, e[63:0]);
                        check("flags32", {62'd0, nv32, nx32}, {62'd0, e[65:64]});
                    end
                end
                if (ov64 && out_ready) begin
                    if (exp64_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $error("FAIL spurious64: observed %h expected no result", y64);
                    end else begin
                        e = exp64_q.pop_front();
                        check("y64", y64, e[63:0]);
                        check("flags64", {62'd0, nv64, nx64}, {62'd0, e[65:64]});
                    end
                end
                hv32 = ov32 && !out_ready;
                h32  = {nv32, nx32, y32};
                hv64 = ov64 && !out_ready;
                h64  = {nv64, nx64, y64};
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (exp32_q.size() != 0 || exp64_q.size() != 0); t++)
            @(posedge clk);
        #1;
        check("drain32", 64'(exp32_q.size()), 64'd0);
        check("drain64", 64'(exp64_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic        found;
        logic [23:0] n;
        logic        s;
        logic [31:0] y;

        rstn      = 1'b0;
        v32       = 1'b0;
        v64       = 1'b0;
        out_ready = 1'b1;
        in_x      = 32'd0;
        in_rm     = 3'd0;
        in_uns    = 1'b0;
        fork monitor(); join_none

        #1;
        check("rst_ov32",  {63'd0, ov32},  64'd0);
        check("rst_y32",   {32'd0, y32},   64'd0);
        check("rst_fl32",  {62'd0, nv32, nx32}, 64'd0);
        check("rst_rdy32", {63'd0, rdy32}, 64'd1);
        check("rst_ov64",  {63'd0, ov64},  64'd0);
        check("rst_y64",   y64,            64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Rounding, signed 32
        send(0, 32'h40200000, RNE, 0, 64'h2, 0, 1);
        send(0, 32'h40600000, RNE, 0, 64'h4, 0, 1);
        send(0, 32'hC0200000, RDN, 0, 64'hFFFFFFFD, 0, 1);
        send(0, 32'hC0200000, RTZ, 0, 64'hFFFFFFFE, 0, 1);
        send(0, 32'h40200000, RUP, 0, 64'h3, 0, 1);
        send(0, 32'hC0200000, RMM, 0, 64'hFFFFFFFD, 0, 1);
        send(0, 32'h40200000, 3'd7, 0, 64'h2, 0, 1);
        send(0, 32'h3F000000, RNE, 0, 64'h0, 0, 1);
        send(0, 32'h3FC00000, RNE, 0, 64'h2, 0, 1);
        send(0, 32'h3FFFFFFF, RNE, 0, 64'h2, 0, 1);
        send(0, 32'h00000001, RUP, 0, 64'h1, 0, 1);
        // Boundaries, signed 32
        send(0, 32'hCF000000, RTZ, 0, 64'h80000000, 0, 0);
        send(0, 32'h4F000000, RTZ, 0, 64'h7FFFFFFF, 1, 0);
        send(0, 32'h4EFFFFFF, RNE, 0, 64'h7FFFFF80, 0, 0);
        send(0, 32'h7FC00000, RNE, 0, 64'h7FFFFFFF, 1, 0);
        send(0, 32'hFFC00000, RNE, 0, 64'h7FFFFFFF, 1, 0);
        send(0, 32'hFF800000, RNE, 0, 64'h80000000, 1, 0);
        // Unsigned 32
        send(0, 32'hBF800000, RTZ, 1, 64'h0, 1, 0);
        send(0, 32'hBE800000, RTZ, 1, 64'h0, 0, 1);
        send(0, 32'h4F7FFFFF, RTZ, 1, 64'hFFFFFF00, 0, 0);
        send(0, 32'h80000000, RDN, 1, 64'h0, 0, 0);
        send(0, 32'h7FC00000, RNE, 1, 64'hFFFFFFFF, 1, 0);
        // 64-bit target
        send(1, 32'h53800000, RNE, 0, 64'h0000010000000000, 0, 0);
        send(1, 32'h7F800000, RNE, 0, 64'h7FFFFFFFFFFFFFFF, 1, 0);
        send(1, 32'hDF000000, RTZ, 0, 64'h8000000000000000, 0, 0);
        send(1, 32'h5F000000, RTZ, 0, 64'h7FFFFFFFFFFFFFFF, 1, 0);
        send(1, 32'h5F000000, RTZ, 1, 64'h8000000000000000, 0, 0);
        send(1, 32'h5F800000, RTZ, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
        send(1, 32'h60000000, RTZ, 0, 64'h7FFFFFFFFFFFFFFF, 1, 0);
        send(1, 32'hFF800000, RTZ, 1, 64'h0, 1, 0);
        drain();

        // Flow control: 8 back-to-back exact integers, 5-cycle stall on first result
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    n = 24'($urandom_range(1, 24'hFFFFFF));
                    s = 1'($urandom_range(0, 1));
                    y = s ? -{8'd0, n} : {8'd0, n};
                    send(0, int2f(s, n), 3'($urandom_range(0, 4)), 0, {32'd0, y}, 0, 0);
                end
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 40 && !found; t++) begin
                    @(posedge clk);
                    #1;
                    found = ov32;
                end
                check("first_out", {63'd0, found}, 64'd1);
                out_ready = 1'b0;
                #1;
                check("in_ready_drop", {63'd0, rdy32}, 64'd0);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        send(0, 32'h40A00000, RTZ, 0, 64'h5, 0, 0);
        send(0, 32'h40C00000, RTZ, 0, 64'h6, 0, 0);
        send(0, 32'h40E00000, RTZ, 0, 64'h7, 0, 0);
        check("inflight_ov", {63'd0, ov32}, 64'd1);
        rstn = 1'b0;
        exp32_q.delete();
        #1;
        check("mid_rst_ov32", {63'd0, ov32}, 64'd0);
        check("mid_rst_y32",  {32'd0, y32},  64'd0);
        check("mid_rst_fl32", {62'd0, nv32, nx32}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("post_rst_rdy", {63'd0, rdy32}, 64'd1);

        // Latency: result visible after the third rising edge counting the accepting one
        @(posedge clk);
        #1;
        in_x  = 32'h40400000;
        in_rm = RTZ;
        in_uns = 1'b0;
        v32   = 1'b1;
        exp32_q.push_back({2'b00, 64'h3});
        @(posedge clk);
        #1 v32 = 1'b0;
        check("lat_edge1", {63'd0, ov32}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2", {63'd0, ov32}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge3", {63'd0, ov32}, 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
